// File: rtl/exmem_forward_pkg.sv
// ============================================================================
// Module      : exmem_forward_pkg
// Description : Shared widths and forwarding-select encoding for exmem_forward.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exmem_forward_pkg;

    localparam int C_REG_IDX_W = 5;
    localparam int C_MEMRD_W   = 3;
    localparam int C_MEMWR_W   = 2;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // A producer matches a consumer only if it writes and the target is not $0.
    function automatic logic reg_hit(
        input logic                   wr_en,
        input logic [C_REG_IDX_W-1:0] dst,
        input logic [C_REG_IDX_W-1:0] src
    );
        return wr_en && (dst != '0) && (dst == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exmem_forward_fwd_sel.sv
// ============================================================================
// Module      : fwd_sel
// Description : Single-operand forwarding mux (EX/MEM over MEM/WB over RF).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_sel
    import exmem_forward_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [C_REG_IDX_W-1:0] i_src,
    input  logic [DW-1:0]          i_rf_data,
    input  logic                   i_m_regwrite,
    input  logic                   i_m_memtoreg,
    input  logic [C_REG_IDX_W-1:0] i_m_dst,
    input  logic [DW-1:0]          i_m_data,
    input  logic                   i_wb_regwrite,
    input  logic [C_REG_IDX_W-1:0] i_wb_dst,
    input  logic [DW-1:0]          i_wb_data,
    output logic [DW-1:0]          o_data
);

    fwd_sel_e w_sel;

    // A load sitting in EX/MEM has no data yet; the load-use stall covers it.
    always_comb begin
        w_sel = FWD_RF;
        if (reg_hit(i_m_regwrite && !i_m_memtoreg, i_m_dst, i_src)) begin
            w_sel = FWD_EXMEM;
        end else if (reg_hit(i_wb_regwrite, i_wb_dst, i_src)) begin
            w_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        o_data = i_rf_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_m_data;
            FWD_MEMWB: o_data = i_wb_data;
            default:   o_data = i_rf_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exmem_forward.sv
// ============================================================================
// Module      : exmem_forward
// Description : EX/MEM pipeline register with operand forwarding and load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exmem_forward
    import exmem_forward_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SCW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C_REG_IDX_W-1:0] rs_e,
    input  logic [C_REG_IDX_W-1:0] rt_e,
    input  logic [C_REG_IDX_W-1:0] rd_e,
    input  logic [DW-1:0]          rfReadData1_e,
    input  logic [DW-1:0]          rfReadData2_e,
    input  logic                   RegDst_e,
    input  logic                   RegWrite_e,
    input  logic                   MemtoReg_e,
    input  logic [C_MEMWR_W-1:0]   MemWrite_e,
    input  logic [C_MEMRD_W-1:0]   MemRead_e,
    input  logic [C_REG_IDX_W-1:0] rs_d,
    input  logic [C_REG_IDX_W-1:0] rt_d,
    input  logic                   wb_RegWrite,
    input  logic [C_REG_IDX_W-1:0] wb_dst,
    input  logic [DW-1:0]          wb_data,
    input  logic [DW-1:0]          alu_y,
    output logic [DW-1:0]          srcA,
    output logic [DW-1:0]          srcB_reg,
    output logic                   stall_d,
    output logic [DW-1:0]          alu_m,
    output logic [DW-1:0]          wdata_m,
    output logic [C_REG_IDX_W-1:0] dst_m,
    output logic                   RegWrite_m,
    output logic                   MemtoReg_m,
    output logic [C_MEMWR_W-1:0]   MemWrite_m,
    output logic [C_MEMRD_W-1:0]   MemRead_m,
    output logic [SCW-1:0]         stall_cnt
);

    logic [C_REG_IDX_W-1:0] w_dst_e;
    logic                   w_stall;
    logic [DW-1:0]          w_src_a;
    logic [DW-1:0]          w_src_b;

    logic [DW-1:0]          r_alu_m;
    logic [DW-1:0]          r_wdata_m;
    logic [C_REG_IDX_W-1:0] r_dst_m;
    logic                   r_regwrite_m;
    logic                   r_memtoreg_m;
    logic [C_MEMWR_W-1:0]   r_memwrite_m;
    logic [C_MEMRD_W-1:0]   r_memread_m;
    logic [SCW-1:0]         r_stall_cnt;

    assign w_dst_e = RegDst_e ? rd_e : rt_e;

    // Load in EX whose destination is read by the instruction in ID.
    assign w_stall = (MemRead_e != '0) && RegWrite_e && (w_dst_e != '0) &&
                     ((w_dst_e == rs_d) || (w_dst_e == rt_d));

    fwd_sel #(
        .DW (DW)
    ) u_fwd_a (
        .i_src         (rs_e),
        .i_rf_data     (rfReadData1_e),
        .i_m_regwrite  (r_regwrite_m),
        .i_m_memtoreg  (r_memtoreg_m),
        .i_m_dst       (r_dst_m),
        .i_m_data      (r_alu_m),
        .i_wb_regwrite (wb_RegWrite),
        .i_wb_dst      (wb_dst),
        .i_wb_data     (wb_data),
        .o_data        (w_src_a)
    );

    fwd_sel #(
        .DW (DW)
    ) u_fwd_b (
        .i_src         (rt_e),
        .i_rf_data     (rfReadData2_e),
        .i_m_regwrite  (r_regwrite_m),
        .i_m_memtoreg  (r_memtoreg_m),
        .i_m_dst       (r_dst_m),
        .i_m_data      (r_alu_m),
        .i_wb_regwrite (wb_RegWrite),
        .i_wb_dst      (wb_dst),
        .i_wb_data     (wb_data),
        .o_data        (w_src_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_m      <= '0;
            r_wdata_m    <= '0;
            r_dst_m      <= '0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= '0;
            r_memread_m  <= '0;
        end else begin
            r_alu_m      <= alu_y;
            r_wdata_m    <= w_src_b;
            r_dst_m      <= w_dst_e;
            r_regwrite_m <= RegWrite_e;
            r_memtoreg_m <= MemtoReg_e;
            r_memwrite_m <= MemWrite_e;
            r_memread_m  <= MemRead_e;
        end
    end

    // Saturating so long-running counts never wrap back to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + SCW'(1);
        end
    end

    assign srcA       = w_src_a;
    assign srcB_reg   = w_src_b;
    assign stall_d    = w_stall;
    assign alu_m      = r_alu_m;
    assign wdata_m    = r_wdata_m;
    assign dst_m      = r_dst_m;
    assign RegWrite_m = r_regwrite_m;
    assign MemtoReg_m = r_memtoreg_m;
    assign MemWrite_m = r_memwrite_m;
    assign MemRead_m  = r_memread_m;
    assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exmem_forward.sv
// ============================================================================
// Module      : tb_exmem_forward
// Description : Self-checking bench for exmem_forward against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exmem_forward;

    localparam int DW      = 32;
    localparam int SCW     = 4;
    localparam int CNT_MAX = (1 << SCW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [4:0]     rs_e, rt_e, rd_e, rs_d, rt_d, wb_dst;
    logic [DW-1:0]  rfReadData1_e, rfReadData2_e, wb_data, alu_y;
    logic           RegDst_e, RegWrite_e, MemtoReg_e, wb_RegWrite;
    logic [1:0]     MemWrite_e;
    logic [2:0]     MemRead_e;
    logic [DW-1:0]  srcA, srcB_reg, alu_m, wdata_m;
    logic           stall_d, RegWrite_m, MemtoReg_m;
    logic [4:0]     dst_m;
    logic [1:0]     MemWrite_m;
    logic [2:0]     MemRead_m;
    logic [SCW-1:0] stall_cnt;

    always #5 clk = ~clk;

    exmem_forward #(.DW(DW), .SCW(SCW)) dut (
        .clk(clk), .rst(rst),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
        .rfReadData1_e(rfReadData1_e), .rfReadData2_e(rfReadData2_e),
        .RegDst_e(RegDst_e), .RegWrite_e(RegWrite_e), .MemtoReg_e(MemtoReg_e),
        .MemWrite_e(MemWrite_e), .MemRead_e(MemRead_e),
        .rs_d(rs_d), .rt_d(rt_d),
        .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst), .wb_data(wb_data),
        .alu_y(alu_y),
        .srcA(srcA), .srcB_reg(srcB_reg), .stall_d(stall_d),
        .alu_m(alu_m), .wdata_m(wdata_m), .dst_m(dst_m),
        .RegWrite_m(RegWrite_m), .MemtoReg_m(MemtoReg_m),
        .MemWrite_m(MemWrite_m), .MemRead_m(MemRead_m),
        .stall_cnt(stall_cnt)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference state of the EX/MEM stage
    logic [DW-1:0] m_alu = '0, m_wdata = '0;
    logic [4:0]    m_dst = '0;
    logic          m_rw = 1'b0, m_mtr = 1'b0;
    logic [1:0]    m_mw = '0;
    logic [2:0]    m_mr = '0;
    int            m_cnt = 0;
    logic [DW-1:0] nx_wdata;
    logic          nx_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_fwd(input logic [4:0] idx, input logic [DW-1:0] rf);
        if (m_rw && !m_mtr && m_dst != 0 && m_dst == idx) return m_alu;
        if (wb_RegWrite && wb_dst != 0 && wb_dst == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic [4:0] exp_dst_e();
        return RegDst_e ? rd_e : rt_e;
    endfunction

    function automatic logic exp_stall();
        logic [4:0] d;
        d = exp_dst_e();
        return (MemRead_e != 0) && RegWrite_e && (d != 0) && (d == rs_d || d == rt_d);
    endfunction

    always @(posedge clk) begin
        nx_wdata = exp_fwd(rt_e, rfReadData2_e);
        nx_stall = exp_stall();
        if (rst) begin
            m_alu = '0; m_wdata = '0; m_dst = '0; m_rw = 1'b0; m_mtr = 1'b0;
            m_mw = '0; m_mr = '0; m_cnt = 0;
        end else begin
            m_alu = alu_y; m_wdata = nx_wdata; m_dst = exp_dst_e();
            m_rw = RegWrite_e; m_mtr = MemtoReg_e; m_mw = MemWrite_e; m_mr = MemRead_e;
            if (nx_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("srcA", srcA, exp_fwd(rs_e, rfReadData1_e));
            chk("srcB_reg", srcB_reg, exp_fwd(rt_e, rfReadData2_e));
            chk("stall_d", stall_d, exp_stall());
            chk("alu_m", alu_m, m_alu);
            chk("wdata_m", wdata_m, m_wdata);
            chk("dst_m", dst_m, m_dst);
            chk("RegWrite_m", RegWrite_m, m_rw);
            chk("MemtoReg_m", MemtoReg_m, m_mtr);
            chk("MemWrite_m", MemWrite_m, m_mw);
            chk("MemRead_m", MemRead_m, m_mr);
            chk("stall_cnt", stall_cnt, m_cnt[SCW-1:0]);
        end
    end

    task automatic clear_in();
        rs_e = 0; rt_e = 0; rd_e = 0; rs_d = 0; rt_d = 0; wb_dst = 0;
        rfReadData1_e = 0; rfReadData2_e = 0; wb_data = 0; alu_y = 0;
        RegDst_e = 0; RegWrite_e = 0; MemtoReg_e = 0; wb_RegWrite = 0;
        MemWrite_e = 0; MemRead_e = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_alu_m", alu_m, 0);
        chk("reset_regwrite_m", RegWrite_m, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        tick();

        // add $3 <- 0x11 enters EX/MEM
        rst = 1'b0;
        RegDst_e = 1; rd_e = 3; RegWrite_e = 1; alu_y = 32'h11;
        tick();
        clear_in();
        rs_e = 3; rt_e = 9; rfReadData1_e = 32'h99;
        wb_RegWrite = 1; wb_dst = 3; wb_data = 32'h22;
        @(negedge clk);
        chk("exmem_priority_srcA", srcA, 32'h11);
        tick();

        clear_in();
        rt_e = 5; rfReadData2_e = 32'h1234;
        wb_RegWrite = 1; wb_dst = 5; wb_data = 32'hAB;
        @(negedge clk);
        chk("memwb_srcB", srcB_reg, 32'hAB);
        tick();
        clear_in();
        @(negedge clk);
        chk("wdata_m_captured", wdata_m, 32'hAB);
        tick();

        // lw $7 in EX, ID reads $7
        RegWrite_e = 1; MemtoReg_e = 1; MemRead_e = 3'b001; rt_e = 7; rs_d = 7;
        @(negedge clk);
        chk("loaduse_stall", stall_d, 1);
        chk("stall_cnt_before", stall_cnt, 0);
        tick();
        rs_d = 8; rt_d = 8;
        @(negedge clk);
        chk("no_stall", stall_d, 0);
        chk("stall_cnt_after", stall_cnt, 1);
        tick();

        // writes to $0 at both stages
        clear_in();
        RegDst_e = 1; rd_e = 0; RegWrite_e = 1; alu_y = 32'h55;
        tick();
        clear_in();
        rs_e = 0; rfReadData1_e = 32'h77;
        wb_RegWrite = 1; wb_dst = 0; wb_data = 32'h66;
        @(negedge clk);
        chk("no_fwd_r0", srcA, 32'h77);
        tick();

        // reset drops an in-flight write
        clear_in();
        RegDst_e = 1; rd_e = 4; RegWrite_e = 1; alu_y = 32'h44;
        tick();
        @(negedge clk);
        chk("inflight_regwrite", RegWrite_m, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        @(negedge clk);
        chk("rst_regwrite_m", RegWrite_m, 0);
        chk("rst_alu_m", alu_m, 0);
        chk("rst_dst_m", dst_m, 0);
        chk("rst_cnt", stall_cnt, 0);

        // saturation: 18 consecutive stall cycles
        RegWrite_e = 1; MemtoReg_e = 1; MemRead_e = 3'b001; rt_e = 7; rs_d = 7;
        repeat (18) tick();
        clear_in();
        @(negedge clk);
        chk("stall_cnt_saturated", stall_cnt, 4'hF);
        tick();

        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 49) == 0);
            rs_e          = 5'($urandom_range(0, 7));
            rt_e          = 5'($urandom_range(0, 7));
            rd_e          = 5'($urandom_range(0, 7));
            rs_d          = 5'($urandom_range(0, 7));
            rt_d          = 5'($urandom_range(0, 7));
            wb_dst        = 5'($urandom_range(0, 7));
            rfReadData1_e = $urandom;
            rfReadData2_e = $urandom;
            wb_data       = $urandom;
            alu_y         = $urandom;
            RegDst_e      = 1'($urandom_range(0, 1));
            RegWrite_e    = 1'($urandom_range(0, 1));
            MemtoReg_e    = 1'($urandom_range(0, 1));
            wb_RegWrite   = 1'($urandom_range(0, 1));
            MemWrite_e    = 2'($urandom_range(0, 3));
            MemRead_e     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick();
        end

        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
